act_stream_unit: RTL and testbench

Streaming activation engine for the MobileNetV3-small datapath. Accepts one signed fixed-point sample per cycle on a valid/ready input, applies the per-beat selected activation (pass, ReLU, h-sigmoid, h-swish), and returns the result on a valid/ready output after a 3-stage pipeline. It is the responder end of the activation interface that conv/depthwise layers and the activation benches drive. It also counts delivered samples.

---
 rtl/act_pkg.sv | 31 +++
 rtl/act_stage_reg.sv | 24 ++
 rtl/act_stream_unit.sv | 144 ++++++++++++++
 tb/tb_act_stream_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared types, constants and saturation helper for the activation stream unit
package act_pkg;

    typedef enum logic [1:0] {
        ACT_PASS   = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_HSIG   = 2'd2,
        ACT_HSWISH = 2'd3
    } act_mode_e;

    // 43/256 approximates 1/6 for the hard-sigmoid divide
    localparam int RECIP6 = 43;
    localparam int RSH    = 8;

    // Clamp a wide signed value into a signed field of the given width
    function automatic logic signed [31:0] saturate(input logic signed [63:0] value,
                                                     input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            saturate = 32'(hi);
        end else if (value < lo) begin
            saturate = 32'(lo);
        end else begin
            saturate = 32'(value);
        end
    endfunction

endpackage

// File: rtl/act_stage_reg.sv
// rtl/act_stage_reg.sv - pipeline stage register holding a valid bit and payload
module act_stage_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_payload,
    output logic             valid,
    output logic [WIDTH-1:0] payload
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            payload <= '0;
        end else if (en) begin
            valid   <= in_valid;
            payload <= in_payload;
        end
    end

endmodule

// File: rtl/act_stream_unit.sv
// rtl/act_stream_unit.sv - 3-stage streaming activation (pass/ReLU/h-sigmoid/h-swish) with sample counter
module act_stream_unit
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]                   in_mode,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic [CNT_WIDTH-1:0]         sample_count
);

    localparam int R_W    = DATA_WIDTH + 2;
    localparam int HSIG_W = R_W + 7;
    localparam int HSW_W  = DATA_WIDTH + R_W + 7;
    localparam int P1_W   = 1 + 2 + R_W + DATA_WIDTH;
    localparam int P2_W   = 1 + 2 + DATA_WIDTH + HSIG_W + HSW_W;
    localparam int P3_W   = 1 + DATA_WIDTH;

    localparam logic signed [R_W-1:0] THREE = R_W'(3 << FRAC_BITS);
    localparam logic signed [R_W-1:0] SIX   = R_W'(6 << FRAC_BITS);

    logic advance;

    // Whole-pipeline stall: every stage, bubbles included, holds when the output is blocked
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // S1: shifted and clamped ramp r = clamp(x + 3, 0, 6)
    logic signed [R_W-1:0] s1_sum;
    logic signed [R_W-1:0] s1_r_next;
    logic [P1_W-1:0]       s1_payload_next;

    always_comb begin
        s1_sum    = {{2{in_data[DATA_WIDTH-1]}}, in_data} + THREE;
        s1_r_next = s1_sum;
        if (s1_sum < 0) begin
            s1_r_next = '0;
        end else if (s1_sum > SIX) begin
            s1_r_next = SIX;
        end
    end

    assign s1_payload_next = {in_last, in_mode, s1_r_next, in_data};

    logic                         s1_valid;
    logic [P1_W-1:0]              s1_payload;
    logic                         s1_last;
    logic [1:0]                   s1_mode;
    logic signed [R_W-1:0]        s1_r;
    logic signed [DATA_WIDTH-1:0] s1_x;

    act_stage_reg #(.WIDTH(P1_W)) u_stage1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (advance),
        .in_valid   (in_valid),
        .in_payload (s1_payload_next),
        .valid      (s1_valid),
        .payload    (s1_payload)
    );

    assign {s1_last, s1_mode, s1_r, s1_x} = s1_payload;

    // S2: full-precision products, no truncation before the final shift
    logic signed [HSIG_W-1:0] s2_hsig_next;
    logic signed [HSW_W-1:0]  s2_hsw_next;

    assign s2_hsig_next = HSIG_W'(s1_r) * HSIG_W'(RECIP6);
    assign s2_hsw_next  = HSW_W'(s1_x) * HSW_W'(s1_r) * HSW_W'(RECIP6);

    logic                         s2_valid;
    logic [P2_W-1:0]              s2_payload;
    logic                         s2_last;
    logic [1:0]                   s2_mode;
    logic signed [DATA_WIDTH-1:0] s2_x;
    logic signed [HSIG_W-1:0]     s2_hsig;
    logic signed [HSW_W-1:0]      s2_hsw;

    act_stage_reg #(.WIDTH(P2_W)) u_stage2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (advance),
        .in_valid   (s1_valid),
        .in_payload ({s1_last, s1_mode, s1_x, s2_hsig_next, s2_hsw_next}),
        .valid      (s2_valid),
        .payload    (s2_payload)
    );

    assign {s2_last, s2_mode, s2_x, s2_hsig, s2_hsw} = s2_payload;

    // S3: per-beat function select; arithmetic shifts floor toward -inf
    logic signed [HSIG_W-1:0]     hsig_sh;
    logic signed [HSW_W-1:0]      hsw_sh;
    logic signed [DATA_WIDTH-1:0] s3_res;

    assign hsig_sh = s2_hsig >>> RSH;
    assign hsw_sh  = s2_hsw >>> (RSH + FRAC_BITS);

    always_comb begin
        s3_res = s2_x;
        case (act_mode_e'(s2_mode))
            ACT_PASS:   s3_res = s2_x;
            ACT_RELU:   s3_res = (s2_x < 0) ? '0 : s2_x;
            ACT_HSIG:   s3_res = DATA_WIDTH'(saturate(64'(hsig_sh), DATA_WIDTH));
            ACT_HSWISH: s3_res = DATA_WIDTH'(saturate(64'(hsw_sh), DATA_WIDTH));
            default:    s3_res = s2_x;
        endcase
    end

    logic [P3_W-1:0] s3_payload;

    act_stage_reg #(.WIDTH(P3_W)) u_stage3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (advance),
        .in_valid   (s2_valid),
        .in_payload ({s2_last, s3_res}),
        .valid      (out_valid),
        .payload    (s3_payload)
    );

    assign out_data = $signed(s3_payload[DATA_WIDTH-1:0]);
    assign out_last = s3_payload[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count <= '0;
        end else if (out_valid && out_ready) begin
            sample_count <= sample_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_act_stream_unit.sv
// tb/tb_act_stream_unit.sv - directed self-checking bench for act_stream_unit
module tb_act_stream_unit;

    localparam int DW = 8;
    localparam int FB = 4;
    localparam int CW = 4;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b1;
    logic                 in_valid  = 1'b0;
    logic signed [DW-1:0] in_data   = '0;
    logic [1:0]           in_mode   = 2'd0;
    logic                 in_last   = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_last;
    logic [CW-1:0]        sample_count;

    int total = 0;
    int bad   = 0;
    logic signed [DW-1:0] exp_d[$];
    logic                 exp_l[$];

    always #5 clk = ~clk;

    act_stream_unit #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_mode      (in_mode),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .sample_count (sample_count)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    // One cycle: drive at the falling edge, then score any transfer due at the next rising edge
    task automatic cycle(input logic v, input logic signed [DW-1:0] d, input logic [1:0] m,
                         input logic l, input logic ordy);
        logic signed [DW-1:0] ed;
        logic                 el;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        in_last   = l;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
                chk("spurious_beat", 32'(out_valid), 0);
            end else begin
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                chk("out_data", out_data, ed);
                chk("out_last", 32'(out_last), 32'(el));
            end
        end
    endtask

    task automatic send(input logic signed [DW-1:0] d, input logic [1:0] m, input logic l,
                        input logic signed [DW-1:0] res);
        exp_d.push_back(res);
        exp_l.push_back(l);
        cycle(1'b1, d, m, l, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_d.size() != 0 && n < bound) begin
            idle();
            n++;
        end
        chk("drain_left", exp_d.size(), 0);
        idle();
    endtask

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_count", 32'(sample_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // ReLU with latency and throughput checks
        send(8'sd0, 2'd1, 1'b0, 8'sd0);
        chk("relu_lat_c1", 32'(out_valid), 0);
        send(8'sd32, 2'd1, 1'b0, 8'sd32);
        chk("relu_lat_c2", 32'(out_valid), 0);
        send(-8'sd16, 2'd1, 1'b1, 8'sd0);
        chk("relu_lat_c3", 32'(out_valid), 0);
        idle();
        chk("relu_lat_c4", 32'(out_valid), 1);
        idle();
        chk("relu_tput_c5", 32'(out_valid), 1);
        idle();
        chk("relu_tput_c6", 32'(out_valid), 1);
        drain(4);
        chk("count_relu", 32'(sample_count), 3);

        // h-sigmoid
        send(8'sd32, 2'd2, 1'b0, 8'sd13);
        send(8'sd64, 2'd2, 1'b0, 8'sd16);
        send(-8'sd64, 2'd2, 1'b1, 8'sd0);
        drain(8);

        // h-swish, including the positive edge of the range and floor rounding
        send(8'sd32, 2'd3, 1'b0, 8'sd26);
        send(-8'sd16, 2'd3, 1'b0, -8'sd6);
        send(8'sd64, 2'd3, 1'b0, 8'sd64);
        send(8'sd127, 2'd3, 1'b1, 8'sd127);
        drain(8);

        // mixed modes back to back, plus most-negative input
        send(-8'sd16, 2'd0, 1'b0, -8'sd16);
        send(-8'sd16, 2'd1, 1'b0, 8'sd0);
        send(-8'sd128, 2'd0, 1'b0, -8'sd128);
        send(-8'sd128, 2'd3, 1'b1, 8'sd0);
        drain(8);
        chk("count_14", 32'(sample_count), 14);

        // counter wrap at 2^CW - 1
        send(8'sd127, 2'd1, 1'b0, 8'sd127);
        drain(8);
        chk("count_15", 32'(sample_count), 15);
        send(-8'sd128, 2'd1, 1'b1, 8'sd0);
        drain(8);
        chk("count_wrap", 32'(sample_count), 0);

        // backpressure mid-stream
        send(8'sd32, 2'd1, 1'b0, 8'sd32);
        send(-8'sd16, 2'd0, 1'b0, -8'sd16);
        send(8'sd64, 2'd2, 1'b0, 8'sd16);
        exp_d.push_back(8'sd127);
        exp_l.push_back(1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'sd127, 2'd3, 1'b1, 1'b0);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", out_data, 32);
            chk("stall_last", 32'(out_last), 0);
            chk("stall_in_ready", 32'(in_ready), 0);
        end
        cycle(1'b1, 8'sd127, 2'd3, 1'b1, 1'b1);
        chk("release_in_ready", 32'(in_ready), 1);
        drain(10);
        chk("count_bp", 32'(sample_count), 4);

        // reset with two beats in flight
        cycle(1'b1, 8'sd32, 2'd1, 1'b0, 1'b1);
        cycle(1'b1, 8'sd64, 2'd1, 1'b0, 1'b1);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_count", 32'(sample_count), 0);
        exp_d.delete();
        exp_l.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("post_rst_c1", 32'(out_valid), 0);
        send(8'sd32, 2'd1, 1'b1, 8'sd32);
        chk("post_rst_lat1", 32'(out_valid), 0);
        idle();
        chk("post_rst_lat2", 32'(out_valid), 0);
        idle();
        chk("post_rst_lat3", 32'(out_valid), 0);
        idle();
        chk("post_rst_lat4", 32'(out_valid), 1);
        drain(4);
        chk("post_rst_count", 32'(sample_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
